mem2p_fifo_ctrl: RTL and testbench

- First-word-fall-through FIFO controller that owns the pointers of a `mem2p_sw_sr` instance (write port 1, registered-address read port 2) and presents valid/ready streaming interfaces on both sides.
- Sits directly upstream of the memory: it drives `we1`/`addr1`/`din1`/`addr2` and consumes `dout2`.
- Gives the queue datapath a buffered, back-pressured element store with full throughput and no extra read latency.

---
 rtl/mem2p_fifo_ctrl_if.sv | 22 ++
 rtl/mem2p_fifo_ctrl.sv | 87 ++++++++
 tb/tb_mem2p_fifo_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem2p_fifo_ctrl_if.sv
// Streaming handshake bundle for mem2p_fifo_ctrl: push side (in_*) and pop side (out_*).
// master = producer/consumer environment, slave = the FIFO controller.
interface mem2p_fifo_ctrl_if #(
   parameter int unsigned W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/mem2p_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving a 2-port memory (write port 1,
// registered-address read port 2); pointers carry a wrap bit above the index bits.
module mem2p_fifo_ctrl #(
   parameter  int unsigned W      = 8,
   parameter  int unsigned D      = 128,
   parameter  int unsigned AF_LVL = D - 2,
   localparam int unsigned DW     = $clog2(D)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   mem2p_fifo_ctrl_if.slave s,
   output logic [DW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic [DW:0]   max_count,
   output logic          mem_we1,
   output logic [DW-1:0] mem_addr1,
   output logic [W-1:0]  mem_din1,
   output logic [DW-1:0] mem_addr2,
   input  logic [W-1:0]  mem_dout2
);

   logic [DW:0] wptr_q, wptr_d;
   logic [DW:0] rptr_q, rptr_d;
   logic [DW:0] max_count_q, max_count_d;
   logic [DW:0] count_c;
   logic [DW:0] next_count_c;
   logic        full_c;
   logic        empty_c;
   logic        push_c;
   logic        pop_c;

   // Occupancy and handshake; flush blocks both sides for the cycle it is high
   always_comb begin
      count_c = wptr_q - rptr_q;
      full_c  = (wptr_q[DW-1:0] == rptr_q[DW-1:0]) && (wptr_q[DW] != rptr_q[DW]);
      empty_c = (wptr_q == rptr_q);

      s.in_ready  = !full_c && !flush;
      s.out_valid = !empty_c && !flush;
      push_c      = s.in_valid && s.in_ready;
      pop_c       = s.out_valid && s.out_ready;
      s.out_data  = mem_dout2;

      count       = count_c;
      full        = full_c;
      empty       = empty_c;
      almost_full = (count_c >= (DW + 1)'(AF_LVL));
      max_count   = max_count_q;
   end

   // Read address looks one entry ahead on a pop so the new head is on dout2 after the edge
   always_comb begin
      mem_we1   = push_c;
      mem_addr1 = wptr_q[DW-1:0];
      mem_din1  = s.in_data;
      mem_addr2 = rptr_q[DW-1:0] + DW'(pop_c);
   end

   always_comb begin
      wptr_d       = wptr_q + (DW + 1)'(push_c);
      rptr_d       = rptr_q + (DW + 1)'(pop_c);
      max_count_d  = max_count_q;
      next_count_c = wptr_d - rptr_d;
      if (flush) begin
         rptr_d      = wptr_q;
         max_count_d = '0;
      end else if (next_count_c > max_count_q) begin
         max_count_d = next_count_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         max_count_q <= '0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         max_count_q <= max_count_d;
      end
   end

endmodule

// File: tb/tb_mem2p_fifo_ctrl.sv
// Bench for mem2p_fifo_ctrl: behavioural memory plus a queue reference model.
module tb_mem2p_fifo_ctrl;
   localparam int unsigned W      = 8;
   localparam int unsigned D      = 8;
   localparam int unsigned AF_LVL = 6;
   localparam int unsigned DW     = $clog2(D);

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic [DW:0]   count;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic [DW:0]   max_count;
   logic          mem_we1;
   logic [DW-1:0] mem_addr1;
   logic [W-1:0]  mem_din1;
   logic [DW-1:0] mem_addr2;
   logic [W-1:0]  mem_dout2;

   mem2p_fifo_ctrl_if #(.W(W)) bus ();

   mem2p_fifo_ctrl #(.W(W), .D(D), .AF_LVL(AF_LVL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .s           (bus),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .max_count   (max_count),
      .mem_we1     (mem_we1),
      .mem_addr1   (mem_addr1),
      .mem_din1    (mem_din1),
      .mem_addr2   (mem_addr2),
      .mem_dout2   (mem_dout2)
   );

   // Memory model: synchronous write, registered read address, async array read
   logic [W-1:0]  ram [D];
   logic [DW-1:0] addr2_q;
   always @(posedge clk) begin
      if (mem_we1) ram[mem_addr1] <= mem_din1;
      addr2_q <= mem_addr2;
   end
   assign mem_dout2 = ram[addr2_q];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   int unsigned  errors = 0;
   int unsigned  checks = 0;
   logic [W-1:0] q[$];
   int unsigned  peak = 0;

   task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      flush         = fl;
      #1;
   endtask

   // Advance one clock, applying the queue rules to the model
   task automatic tick();
      bit           push_m, pop_m;
      logic [W-1:0] d;
      push_m = bus.in_valid && (q.size() < D) && !flush;
      pop_m  = !flush && (q.size() > 0) && bus.out_ready;
      d      = bus.in_data;
      @(posedge clk);
      if (flush) begin
         q.delete();
         peak = 0;
      end else begin
         if (pop_m) void'(q.pop_front());
         if (push_m) q.push_back(d);
         if (q.size() > peak) peak = q.size();
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", almost_full); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
      checks++; if (mem_we1 !== 1'b0) begin errors++; $display("FAIL reset_we1 got %b exp 0", mem_we1); end
      checks++; if (mem_addr1 !== 3'd0 || mem_addr2 !== 3'd0) begin errors++; $display("FAIL reset_addr got %0d/%0d exp 0/0", mem_addr1, mem_addr2); end
      checks++; if (max_count !== 4'd0) begin errors++; $display("FAIL reset_max got %0d exp 0", max_count); end
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      peak = 0;
   endtask

   task automatic test_basic();
      logic [W-1:0] exp_d [3];
      exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, exp_d[i], 1'b0, 1'b0);
         checks++; if (mem_we1 !== 1'b1 || mem_addr1 !== 3'(i)) begin errors++; $display("FAIL basic_wr%0d got we=%b a=%0d exp we=1 a=%0d", i, mem_we1, mem_addr1, i); end
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++; if (count !== 4'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", count); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11) begin errors++; $display("FAIL basic_head got v=%b d=%h exp v=1 d=11", bus.out_valid, bus.out_data); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[i]) begin errors++; $display("FAIL basic_pop%0d got v=%b d=%h exp v=1 d=%h", i, bus.out_valid, bus.out_data, exp_d[i]); end
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++; if (empty !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got e=%b v=%b exp e=1 v=0", empty, bus.out_valid); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
         tick();
         drive(1'b0, '0, 1'b0, 1'b0);
         checks++; if (almost_full !== (i + 1 >= 6)) begin errors++; $display("FAIL full_af%0d got %b exp %b", i + 1, almost_full, (i + 1 >= 6)); end
         checks++; if (full !== (i + 1 == 8)) begin errors++; $display("FAIL full_flag%0d got %b exp %b", i + 1, full, (i + 1 == 8)); end
      end
      drive(1'b1, 8'hEE, 1'b1, 1'b0);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", bus.in_ready); end
      checks++; if (bus.out_data !== 8'hA0) begin errors++; $display("FAIL full_head got %h exp a0", bus.out_data); end
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_count7 got %0d exp 7", count); end
      checks++; if (max_count !== 4'd8) begin errors++; $display("FAIL full_max got %0d exp 8", max_count); end
      for (int i = 1; i < 8; i++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL full_pop%0d got v=%b d=%h exp v=1 d=%h", i, bus.out_valid, bus.out_data, 8'hA0 + 8'(i)); end
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained got %b exp 1", empty); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 8'(i), 1'b1, 1'b0);
         checks++; if (count !== ((i > 0) ? 4'd1 : 4'd0)) begin errors++; $display("FAIL stream_count%0d got %0d exp %0d", i, count, (i > 0) ? 1 : 0); end
         if (i > 0) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i - 1)) begin errors++; $display("FAIL stream_data%0d got v=%b d=%0d exp v=1 d=%0d", i, bus.out_valid, bus.out_data, i - 1); end
         end
         tick();
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (bus.out_data !== 8'd39) begin errors++; $display("FAIL stream_last got %0d exp 39", bus.out_data); end
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty got %b exp 1", empty); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 8'h99, 1'b1, 1'b1);
      checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_hs got r=%b v=%b exp r=0 v=0", bus.in_ready, bus.out_valid); end
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_count got c=%0d e=%b exp c=0 e=1", count, empty); end
      checks++; if (max_count !== 4'd0) begin errors++; $display("FAIL flush_max got %0d exp 0", max_count); end
      drive(1'b1, 8'h77, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++; if (count !== 4'd1 || bus.out_data !== 8'h77) begin errors++; $display("FAIL flush_after got c=%0d d=%h exp c=1 d=77", count, bus.out_data); end
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'($urandom), 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      q.delete();
      peak = 0;
      checks++; if (count !== 4'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_now got c=%0d v=%b r=%b exp c=0 v=0 r=1", count, bus.out_valid, bus.in_ready); end
      checks++; if (max_count !== 4'd0) begin errors++; $display("FAIL arst_max got %0d exp 0", max_count); end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 8'h5A, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A || count !== 4'd1) begin errors++; $display("FAIL arst_push got v=%b d=%h c=%0d exp v=1 d=5a c=1", bus.out_valid, bus.out_data, count); end
   endtask

   task automatic test_random();
      int unsigned pin, pout;
      logic        fl;
      for (int c = 0; c < 1000; c++) begin
         if (c % 100 == 0) begin
            pin  = $urandom_range(20, 90);
            pout = $urandom_range(20, 90);
         end
         fl = ($urandom_range(0, 59) == 0);
         drive(($urandom_range(0, 99) < pin), 8'($urandom), ($urandom_range(0, 99) < pout), fl);
         checks++; if (count !== 4'(q.size())) begin errors++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, count, q.size()); end
         checks++; if (bus.in_ready !== ((q.size() < D) && !fl)) begin errors++; $display("FAIL rnd_in_ready c%0d got %b exp %b", c, bus.in_ready, (q.size() < D) && !fl); end
         checks++; if (bus.out_valid !== ((q.size() > 0) && !fl)) begin errors++; $display("FAIL rnd_out_valid c%0d got %b exp %b", c, bus.out_valid, (q.size() > 0) && !fl); end
         checks++; if (full !== (q.size() == D) || empty !== (q.size() == 0) || almost_full !== (q.size() >= AF_LVL)) begin errors++; $display("FAIL rnd_flags c%0d got f=%b e=%b af=%b exp size=%0d", c, full, empty, almost_full, q.size()); end
         checks++; if (max_count !== 4'(peak)) begin errors++; $display("FAIL rnd_max c%0d got %0d exp %0d", c, max_count, peak); end
         if (q.size() > 0) begin
            checks++; if (bus.out_data !== q[0]) begin errors++; $display("FAIL rnd_data c%0d got %h exp %h", c, bus.out_data, q[0]); end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
